regwrite_checker: RTL and testbench

- Synthesizable self-checking harness for the single-cycle processor skeleton.
- Sequences the processor's reset and watches its register-file write port (write enable, write register, write data).
- Compares each architectural write in order against an expected-write table and reports pass/fail, error count, first mismatch and timeout.
- Replaces hand-written per-program testbenches; table depth, data width and timeout are parametrised.

---
 rtl/regwrite_checker.sv | 161 ++++++++++++++++
 tb/tb_regwrite_checker.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regwrite_checker.sv
// Self-checking harness for the single-cycle processor. It sequences the processor reset,
// then compares each register-file write, in order, against an expected-write table.
module regwrite_checker #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int EXP_AW         = 8,
    parameter int RESET_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int ERR_WIDTH      = 16,
    parameter int IGNORE_R0      = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    output logic                      dut_reset,
    input  logic                      wb_en,
    input  logic [REG_ADDR_WIDTH-1:0] wb_reg,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    input  logic [EXP_AW:0]           exp_count,
    output logic [EXP_AW-1:0]         exp_addr,
    input  logic [REG_ADDR_WIDTH-1:0] exp_reg,
    input  logic [DATA_WIDTH-1:0]     exp_data,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic                      timeout,
    output logic [ERR_WIDTH-1:0]      error_count,
    output logic [EXP_AW-1:0]         bad_idx,
    output logic [DATA_WIDTH-1:0]     bad_data,
    output logic [31:0]               cycle_count
);

    localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RESET_DUT, S_RUN, S_DONE} state_t;

    state_t                  r_state;
    logic [EXP_AW:0]         r_count;
    logic [RCW-1:0]          r_rst_cnt;
    logic                    r_dut_reset;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_pass;
    logic                    r_timeout;
    logic [ERR_WIDTH-1:0]    r_error_count;
    logic [EXP_AW-1:0]       r_exp_addr;
    logic [EXP_AW-1:0]       r_bad_idx;
    logic [DATA_WIDTH-1:0]   r_bad_data;
    logic [31:0]             r_cycle_count;

    logic                    w_launch;
    logic                    w_checked;
    logic                    w_mismatch;
    logic                    w_last;
    logic                    w_timeout_hit;
    logic [EXP_AW:0]         w_addr_next;
    logic [ERR_WIDTH-1:0]    w_err_next;

    assign w_launch      = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_checked     = wb_en && !((IGNORE_R0 != 0) && (wb_reg == '0));
    assign w_mismatch    = (wb_reg != exp_reg) || (wb_data != exp_data);
    assign w_addr_next   = {1'b0, r_exp_addr} + {{EXP_AW{1'b0}}, 1'b1};
    // The entry being checked is the final one when its index+1 equals the latched count.
    assign w_last        = (w_addr_next == r_count);
    assign w_timeout_hit = (r_cycle_count == 32'(TIMEOUT_CYCLES - 1));
    assign w_err_next    = (w_checked && w_mismatch && !(&r_error_count))
                           ? r_error_count + ERR_WIDTH'(1) : r_error_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_rst_cnt     <= '0;
            r_dut_reset   <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_timeout     <= 1'b0;
            r_error_count <= '0;
            r_exp_addr    <= '0;
            r_bad_idx     <= '0;
            r_bad_data    <= '0;
            r_cycle_count <= '0;
        end else if (w_launch) begin
            r_state       <= S_RESET_DUT;
            r_count       <= exp_count;
            r_rst_cnt     <= '0;
            r_dut_reset   <= 1'b1;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_timeout     <= 1'b0;
            r_error_count <= '0;
            r_exp_addr    <= '0;
            r_bad_idx     <= '0;
            r_bad_data    <= '0;
            r_cycle_count <= '0;
        end else begin
            case (r_state)
                S_RESET_DUT: begin
                    if (r_rst_cnt == RCW'(RESET_CYCLES - 1)) begin
                        r_dut_reset <= 1'b0;
                        if (r_count == '0) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end else begin
                        r_rst_cnt <= r_rst_cnt + RCW'(1);
                    end
                end
                S_RUN: begin
                    r_cycle_count <= r_cycle_count + 32'd1;
                    if (w_checked) begin
                        r_error_count <= w_err_next;
                        if (w_mismatch && r_error_count == '0) begin
                            r_bad_idx  <= r_exp_addr;
                            r_bad_data <= wb_data;
                        end
                    end
                    // Completion takes priority over a timeout landing in the same cycle.
                    if (w_checked && w_last) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == '0);
                    end else begin
                        if (w_checked) begin
                            r_exp_addr <= r_exp_addr + EXP_AW'(1);
                        end
                        if (w_timeout_hit) begin
                            r_state   <= S_DONE;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_pass    <= 1'b0;
                            r_timeout <= 1'b1;
                        end
                    end
                end
                S_IDLE, S_DONE: begin
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dut_reset   = r_dut_reset;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign timeout     = r_timeout;
    assign error_count = r_error_count;
    assign exp_addr    = r_exp_addr;
    assign bad_idx     = r_bad_idx;
    assign bad_data    = r_bad_data;
    assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_regwrite_checker.sv
// Bench for regwrite_checker: two instances (r0 ignored / r0 checked) share one stimulus
// stream; expected end-of-run results come from a hand-derived vector table via a queue.
module tb_regwrite_checker;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_reg = '0;
    logic [31:0] wb_data = '0;
    logic [8:0]  exp_count = '0;

    logic        dut_reset_a, busy_a, done_a, pass_a, timeout_a;
    logic [7:0]  exp_addr_a, bad_idx_a;
    logic [4:0]  exp_reg_a;
    logic [31:0] exp_data_a, bad_data_a, cycle_count_a;
    logic [15:0] error_count_a;

    logic        dut_reset_b, busy_b, done_b, pass_b, timeout_b;
    logic [7:0]  exp_addr_b, bad_idx_b;
    logic [4:0]  exp_reg_b;
    logic [31:0] exp_data_b, bad_data_b, cycle_count_b;
    logic [15:0] error_count_b;

    logic [4:0]  mem_reg [256];
    logic [31:0] mem_dat [256];

    assign exp_reg_a  = mem_reg[exp_addr_a];
    assign exp_data_a = mem_dat[exp_addr_a];
    assign exp_reg_b  = mem_reg[exp_addr_b];
    assign exp_data_b = mem_dat[exp_addr_b];

    always #5 clock = ~clock;

    regwrite_checker #(.TIMEOUT_CYCLES(16), .IGNORE_R0(1)) u_dut_a (
        .clock(clock), .reset(reset), .start(start), .dut_reset(dut_reset_a),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .exp_count(exp_count),
        .exp_addr(exp_addr_a), .exp_reg(exp_reg_a), .exp_data(exp_data_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .timeout(timeout_a),
        .error_count(error_count_a), .bad_idx(bad_idx_a), .bad_data(bad_data_a),
        .cycle_count(cycle_count_a)
    );

    regwrite_checker #(.TIMEOUT_CYCLES(16), .IGNORE_R0(0)) u_dut_b (
        .clock(clock), .reset(reset), .start(start), .dut_reset(dut_reset_b),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .exp_count(exp_count),
        .exp_addr(exp_addr_b), .exp_reg(exp_reg_b), .exp_data(exp_data_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .timeout(timeout_b),
        .error_count(error_count_b), .bad_idx(bad_idx_b), .bad_data(bad_data_b),
        .cycle_count(cycle_count_b)
    );

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
        logic [4:0]  gap;
    } wr_t;

    typedef struct packed {
        logic [8:0]  cnt;
        logic [7:0]  wfirst;
        logic [3:0]  nw;
        logic [15:0] err_a;
        logic [7:0]  bidx_a;
        logic [31:0] bdat_a;
        logic        pass_a;
        logic        tmo;
        logic [7:0]  addr_a;
        logic [31:0] cyc_a;
        logic [15:0] err_b;
        logic [7:0]  bidx_b;
        logic        pass_b;
    } vec_t;

    wr_t  wl [16];
    vec_t vt [7];
    vec_t sb [$];

    int checks = 0;
    int errors = 0;

    function automatic wr_t mkw(int r, int d, int g);
        wr_t w;
        w.r = 5'(r);
        w.d = 32'(d);
        w.gap = 5'(g);
        return w;
    endfunction

    function automatic vec_t mkv(int cnt, int wf, int nw, int ea, int ba, int bd, int pa,
                                 int to, int ad, int cy, int eb, int bb, int pb);
        vec_t v;
        v.cnt = 9'(cnt);   v.wfirst = 8'(wf);  v.nw = 4'(nw);
        v.err_a = 16'(ea); v.bidx_a = 8'(ba);  v.bdat_a = 32'(bd);
        v.pass_a = 1'(pa); v.tmo = 1'(to);     v.addr_a = 8'(ad);
        v.cyc_a = 32'(cy); v.err_b = 16'(eb);  v.bidx_b = 8'(bb);
        v.pass_b = 1'(pb);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        vec_t e;
        wr_t  w;
        int   n;
        v = vt[i];
        exp_count = v.cnt;
        @(negedge clock);
        start = 1'b1;
        sb.push_back(v);
        @(negedge clock);
        start = 1'b0;
        chk($sformatf("v%0d_busy_after_start", i), busy_a, 1);
        chk($sformatf("v%0d_done_cleared", i), done_a, 0);
        chk($sformatf("v%0d_err_cleared", i), error_count_a, 0);
        n = 0;
        while (dut_reset_a && n < 20) begin
            n++;
            @(negedge clock);
        end
        chk($sformatf("v%0d_dut_reset_cycles", i), n, 2);
        for (int k = 0; k < int'(v.nw); k++) begin
            w = wl[int'(v.wfirst) + k];
            wb_en = 1'b0;
            repeat (int'(w.gap)) @(negedge clock);
            wb_en = 1'b1;
            wb_reg = w.r;
            wb_data = w.d;
            @(negedge clock);
            wb_en = 1'b0;
        end
        if (i == 0) chk("v0_done_cycle_after_last_write", done_a, 1);
        n = 0;
        while (!(done_a && done_b) && n < 64) begin
            n++;
            @(negedge clock);
        end
        chk($sformatf("v%0d_done_reached", i), done_a && done_b, 1);
        e = sb.pop_front();
        chk($sformatf("v%0d_err_a", i), error_count_a, e.err_a);
        chk($sformatf("v%0d_bad_idx_a", i), bad_idx_a, e.bidx_a);
        chk($sformatf("v%0d_bad_data_a", i), bad_data_a, e.bdat_a);
        chk($sformatf("v%0d_pass_a", i), pass_a, e.pass_a);
        chk($sformatf("v%0d_timeout_a", i), timeout_a, e.tmo);
        chk($sformatf("v%0d_exp_addr_a", i), exp_addr_a, e.addr_a);
        chk($sformatf("v%0d_cycles_a", i), cycle_count_a, e.cyc_a);
        chk($sformatf("v%0d_busy_a_done", i), busy_a, 0);
        chk($sformatf("v%0d_dut_reset_a_done", i), dut_reset_a, 0);
        chk($sformatf("v%0d_err_b", i), error_count_b, e.err_b);
        chk($sformatf("v%0d_bad_idx_b", i), bad_idx_b, e.bidx_b);
        chk($sformatf("v%0d_pass_b", i), pass_b, e.pass_b);
        chk($sformatf("v%0d_timeout_b", i), timeout_b, e.tmo);
    endtask

    task automatic midrun_reset();
        int n;
        exp_count = 9'd4;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (dut_reset_a && n < 20) begin
            n++;
            @(negedge clock);
        end
        wb_en = 1'b1; wb_reg = 5'd1; wb_data = 32'd5;
        @(negedge clock);
        wb_reg = 5'd2; wb_data = 32'd8;
        @(negedge clock);
        wb_en = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("run_start_ignored_addr", exp_addr_a, 2);
        chk("run_start_ignored_err", error_count_a, 1);
        chk("run_start_ignored_busy", busy_a, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_dut_reset", dut_reset_a, 1);
        chk("async_rst_busy", busy_a, 0);
        chk("async_rst_err", error_count_a, 0);
        chk("async_rst_addr", exp_addr_a, 0);
        chk("async_rst_cycles", cycle_count_a, 0);
        chk("async_rst_bad_data", bad_data_a, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("idle_after_rst_busy", busy_a, 0);
        chk("idle_after_rst_done", done_a, 0);
        chk("idle_after_rst_dut_reset", dut_reset_a, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 256; a++) begin
            mem_reg[a] = '0;
            mem_dat[a] = '0;
        end
        mem_reg[0] = 5'd1; mem_dat[0] = 32'd5;
        mem_reg[1] = 5'd2; mem_dat[1] = 32'd7;
        mem_reg[2] = 5'd3; mem_dat[2] = 32'd12;
        mem_reg[3] = 5'd4; mem_dat[3] = 32'd20;

        wl[0]  = mkw(1, 5, 0);  wl[1]  = mkw(2, 7, 0);  wl[2]  = mkw(3, 12, 0);
        wl[3]  = mkw(1, 5, 0);  wl[4]  = mkw(2, 8, 0);  wl[5]  = mkw(3, 12, 0);
        wl[6]  = mkw(1, 5, 0);  wl[7]  = mkw(0, 99, 0); wl[8]  = mkw(2, 7, 0);
        wl[9]  = mkw(3, 12, 0); wl[10] = mkw(1, 5, 0);  wl[11] = mkw(2, 7, 0);
        wl[12] = mkw(3, 12, 0); wl[13] = mkw(4, 20, 12);
        wl[14] = mkw(1, 6, 0);  wl[15] = mkw(5, 7, 2);

        //         cnt wf nw  errA bidxA bdatA passA tmo addrA cycA  errB bidxB passB
        vt[0] = mkv(3,  0, 3,  0,   0,    0,    1,    0,  2,    3,    0,   0,    1);
        vt[1] = mkv(3,  3, 3,  1,   1,    8,    0,    0,  2,    3,    1,   1,    0);
        vt[2] = mkv(3,  6, 4,  0,   0,    0,    1,    0,  2,    4,    2,   1,    0);
        vt[3] = mkv(4,  0, 2,  0,   0,    0,    0,    1,  2,    16,   0,   0,    0);
        vt[4] = mkv(4, 10, 4,  0,   0,    0,    1,    0,  3,    16,   0,   0,    1);
        vt[5] = mkv(2, 14, 2,  2,   0,    6,    0,    0,  1,    4,    2,   0,    0);
        vt[6] = mkv(0,  0, 0,  0,   0,    0,    1,    0,  0,    0,    0,   0,    1);

        repeat (2) @(negedge clock);
        chk("rst_dut_reset", dut_reset_a, 1);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0);
        chk("rst_timeout", timeout_a, 0);
        chk("rst_err", error_count_a, 0);
        chk("rst_addr", exp_addr_a, 0);
        chk("rst_cycles", cycle_count_a, 0);
        reset = 1'b1;
        @(negedge clock);
        chk("idle_dut_reset", dut_reset_a, 1);

        for (int i = 0; i < 6; i++) run_vec(i);
        midrun_reset();
        run_vec(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
